// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory access stage: access sizes, FSM states,
// exception codes and the small lane/alignment helpers used at issue time.
package mem_access_stage_pkg;

   // Access size encoding as delivered by execute (3 is reserved, handled as word)
   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2,
      SZ_RSVD = 2'd3
   } size_e;

   // Stage sequencing: idle (accepting) or waiting on the data memory
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } state_e;

   // Exception cause codes consumed by writeback / CP0
   localparam logic [4:0] EXC_CODE_NONE = 5'd0;
   localparam logic [4:0] EXC_CODE_ADEL = 5'd4;
   localparam logic [4:0] EXC_CODE_ADES = 5'd5;
   localparam logic [4:0] EXC_CODE_DBE  = 5'd7;
   localparam logic [4:0] EXC_CODE_OV   = 5'd12;

   // Per-instruction context that must survive an outstanding access
   typedef struct packed {
      logic [1:0] offset;
      logic [1:0] size;
      logic       load_unsigned;
      logic       is_load;
      logic       gp_we;
      logic [4:0] cad;
   } op_t;

   // Halfwords need even addresses, words (and reserved) need 4-byte alignment
   function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
      logic mis;
      case (sz)
         SZ_BYTE: mis = 1'b0;
         SZ_HALF: mis = off[0];
         default: mis = (off != 2'b00);
      endcase
      return mis;
   endfunction

   // Little-endian lane enables for an aligned access
   function automatic logic [3:0] byte_enables(input logic [1:0] sz, input logic [1:0] off);
      logic [3:0] be;
      case (sz)
         SZ_BYTE: be = 4'b0001 << off;
         SZ_HALF: be = 4'b0011 << off;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   // Replicate store data across all lanes so any enabled lane carries it
   function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] data);
      logic [31:0] wd;
      case (sz)
         SZ_BYTE: wd = {4{data[7:0]}};
         SZ_HALF: wd = {2{data[15:0]}};
         default: wd = data;
      endcase
      return wd;
   endfunction

   // Encode the (mutually exclusive) exception flags into a cause code
   function automatic logic [4:0] exc_code(input logic ovf, input logic adel,
                                           input logic ades, input logic bus);
      logic [4:0] code;
      if (ovf) begin
         code = EXC_CODE_OV;
      end else if (adel) begin
         code = EXC_CODE_ADEL;
      end else if (ades) begin
         code = EXC_CODE_ADES;
      end else if (bus) begin
         code = EXC_CODE_DBE;
      end else begin
         code = EXC_CODE_NONE;
      end
      return code;
   endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Bundle of the execute-side, data-memory and writeback signals of the stage.
// master = environment (execute + memory + writeback), slave = the stage.
interface mem_access_stage_if;
   // execute -> stage
   logic        in_valid;
   logic        in_ready;
   logic [31:0] alu_res;
   logic [31:0] shift_res;
   logic [31:0] dm_in;
   logic [31:0] ea;
   logic        ovfalu;
   logic        res_sel;
   logic        mem_rren;
   logic        mem_wren;
   logic [1:0]  size;
   logic        load_unsigned;
   logic [4:0]  cad;
   logic        gp_we;
   // stage <-> data memory
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   // stage -> writeback
   logic        wb_valid;
   logic        wb_we;
   logic [4:0]  wb_cad;
   logic [31:0] wb_data;
   logic        exc_ovf;
   logic        exc_adel;
   logic        exc_ades;
   logic        exc_bus;

   modport master (
      output in_valid, alu_res, shift_res, dm_in, ea, ovfalu, res_sel,
             mem_rren, mem_wren, size, load_unsigned, cad, gp_we,
             dmem_ack, dmem_rdata,
      input  in_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
             wb_valid, wb_we, wb_cad, wb_data,
             exc_ovf, exc_adel, exc_ades, exc_bus
   );

   modport slave (
      input  in_valid, alu_res, shift_res, dm_in, ea, ovfalu, res_sel,
             mem_rren, mem_wren, size, load_unsigned, cad, gp_we,
             dmem_ack, dmem_rdata,
      output in_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
             wb_valid, wb_we, wb_cad, wb_data,
             exc_ovf, exc_adel, exc_ades, exc_bus
   );
endinterface

// File: rtl/mem_access_stage_load_align.sv
// Load alignment: picks the addressed byte/halfword out of the read word and
// sign- or zero-extends it to 32 bits. Word (and reserved) sizes pass through.
module mem_access_stage_load_align
   import mem_access_stage_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  offset_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Lane select followed by extension according to size and signedness
   always_comb begin
      byte_s = 8'h00;
      half_s = 16'h0000;
      data_o = word_i;
      case (offset_i)
         2'd0:    byte_s = word_i[7:0];
         2'd1:    byte_s = word_i[15:8];
         2'd2:    byte_s = word_i[23:16];
         2'd3:    byte_s = word_i[31:24];
         default: byte_s = word_i[7:0];
      endcase
      if (offset_i[1]) begin
         half_s = word_i[31:16];
      end else begin
         half_s = word_i[15:0];
      end
      case (size_i)
         SZ_BYTE: data_o = unsigned_i ? {24'h000000, byte_s} : {{24{byte_s[7]}}, byte_s};
         SZ_HALF: data_o = unsigned_i ? {16'h0000, half_s}   : {{16{half_s[15]}}, half_s};
         default: data_o = word_i;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// Memory access stage: registers execute results, issues byte/half/word
// loads and stores on a req/ack data port with a bounded wait, and emits one
// registered writeback pulse per instruction. Upstream stalls while an
// access is outstanding.
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT = 255
)(
   input  logic              clk,
   input  logic              reset,
   mem_access_stage_if.slave bus
);

   localparam logic [7:0] TIMEOUT_C = 8'(ACK_TIMEOUT);

   state_e      state_q, state_d;
   op_t         op_q, op_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        in_ready_q, in_ready_d;
   logic        dmem_req_q, dmem_req_d;
   logic        dmem_we_q, dmem_we_d;
   logic [31:0] dmem_addr_q, dmem_addr_d;
   logic [3:0]  dmem_be_q, dmem_be_d;
   logic [31:0] dmem_wdata_q, dmem_wdata_d;
   logic        wb_valid_q, wb_valid_d;
   logic        wb_we_q, wb_we_d;
   logic [4:0]  wb_cad_q, wb_cad_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic        exc_ovf_q, exc_ovf_d;
   logic        exc_adel_q, exc_adel_d;
   logic        exc_ades_q, exc_ades_d;
   logic        exc_bus_q, exc_bus_d;

   logic        accept_s;
   logic        is_mem_s;
   logic        mis_s;
   logic        issue_s;
   logic [7:0]  cnt_inc_s;
   logic        timeout_s;
   logic [31:0] load_data_s;

   // Decode of the instruction offered by execute
   always_comb begin
      accept_s  = bus.in_valid & in_ready_q;
      is_mem_s  = bus.mem_rren | bus.mem_wren;
      mis_s     = is_misaligned(bus.size, bus.ea[1:0]);
      issue_s   = is_mem_s & ~bus.ovfalu & ~mis_s;
      cnt_inc_s = cnt_q + 8'd1;
      timeout_s = (cnt_inc_s == TIMEOUT_C);
   end

   mem_access_stage_load_align u_load_align (
      .word_i     (bus.dmem_rdata),
      .offset_i   (op_q.offset),
      .size_i     (op_q.size),
      .unsigned_i (op_q.load_unsigned),
      .data_o     (load_data_s)
   );

   // Next-state and registered-output computation for the stage FSM
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      cnt_d        = cnt_q;
      dmem_we_d    = dmem_we_q;
      dmem_addr_d  = dmem_addr_q;
      dmem_be_d    = dmem_be_q;
      dmem_wdata_d = dmem_wdata_q;
      wb_valid_d   = 1'b0;
      wb_we_d      = 1'b0;
      wb_cad_d     = wb_cad_q;
      wb_data_d    = wb_data_q;
      exc_ovf_d    = 1'b0;
      exc_adel_d   = 1'b0;
      exc_ades_d   = 1'b0;
      exc_bus_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               op_d.offset        = bus.ea[1:0];
               op_d.size          = bus.size;
               op_d.load_unsigned = bus.load_unsigned;
               op_d.is_load       = bus.mem_rren;
               op_d.gp_we         = bus.gp_we;
               op_d.cad           = bus.cad;
               if (issue_s) begin
                  state_d      = ST_REQ;
                  cnt_d        = 8'd0;
                  dmem_we_d    = bus.mem_wren;
                  dmem_addr_d  = {bus.ea[31:2], 2'b00};
                  dmem_be_d    = byte_enables(bus.size, bus.ea[1:0]);
                  dmem_wdata_d = store_data(bus.size, bus.dm_in);
               end else begin
                  // Completes immediately: plain result or a faulting access
                  wb_valid_d = 1'b1;
                  wb_cad_d   = bus.cad;
                  exc_ovf_d  = bus.ovfalu;
                  exc_adel_d = ~bus.ovfalu & bus.mem_rren & mis_s;
                  exc_ades_d = ~bus.ovfalu & bus.mem_wren & mis_s;
                  wb_we_d    = bus.gp_we & ~bus.ovfalu & ~is_mem_s;
                  if (is_mem_s) begin
                     wb_data_d = 32'h0000_0000;
                  end else begin
                     wb_data_d = bus.res_sel ? bus.shift_res : bus.alu_res;
                  end
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (bus.dmem_ack) begin
               state_d    = ST_IDLE;
               dmem_we_d  = 1'b0;
               wb_valid_d = 1'b1;
               wb_cad_d   = op_q.cad;
               wb_we_d    = op_q.is_load & op_q.gp_we;
               wb_data_d  = op_q.is_load ? load_data_s : 32'h0000_0000;
            end else if (timeout_s) begin
               state_d    = ST_IDLE;
               dmem_we_d  = 1'b0;
               wb_valid_d = 1'b1;
               wb_cad_d   = op_q.cad;
               wb_data_d  = 32'h0000_0000;
               exc_bus_d  = 1'b1;
            end else begin
               cnt_d = cnt_inc_s;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            dmem_we_d = 1'b0;
         end
      endcase
      in_ready_d = (state_d == ST_IDLE);
      dmem_req_d = (state_d == ST_REQ);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         op_q         <= '0;
         cnt_q        <= 8'd0;
         in_ready_q   <= 1'b1;
         dmem_req_q   <= 1'b0;
         dmem_we_q    <= 1'b0;
         dmem_addr_q  <= 32'h0000_0000;
         dmem_be_q    <= 4'b0000;
         dmem_wdata_q <= 32'h0000_0000;
         wb_valid_q   <= 1'b0;
         wb_we_q      <= 1'b0;
         wb_cad_q     <= 5'd0;
         wb_data_q    <= 32'h0000_0000;
         exc_ovf_q    <= 1'b0;
         exc_adel_q   <= 1'b0;
         exc_ades_q   <= 1'b0;
         exc_bus_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         cnt_q        <= cnt_d;
         in_ready_q   <= in_ready_d;
         dmem_req_q   <= dmem_req_d;
         dmem_we_q    <= dmem_we_d;
         dmem_addr_q  <= dmem_addr_d;
         dmem_be_q    <= dmem_be_d;
         dmem_wdata_q <= dmem_wdata_d;
         wb_valid_q   <= wb_valid_d;
         wb_we_q      <= wb_we_d;
         wb_cad_q     <= wb_cad_d;
         wb_data_q    <= wb_data_d;
         exc_ovf_q    <= exc_ovf_d;
         exc_adel_q   <= exc_adel_d;
         exc_ades_q   <= exc_ades_d;
         exc_bus_q    <= exc_bus_d;
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.dmem_req   = dmem_req_q;
   assign bus.dmem_we    = dmem_we_q;
   assign bus.dmem_addr  = dmem_addr_q;
   assign bus.dmem_be    = dmem_be_q;
   assign bus.dmem_wdata = dmem_wdata_q;
   assign bus.wb_valid   = wb_valid_q;
   assign bus.wb_we      = wb_we_q;
   assign bus.wb_cad     = wb_cad_q;
   assign bus.wb_data    = wb_data_q;
   assign bus.exc_ovf    = exc_ovf_q;
   assign bus.exc_adel   = exc_adel_q;
   assign bus.exc_ades   = exc_ades_q;
   assign bus.exc_bus    = exc_bus_q;

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory stage directly downstream of the execute stage. Captures execute results (ALU, shifter, effective address, store data, overflow) with their control bits. Performs byte/halfword/word loads and stores over a request/acknowledge data-memory port with a bounded wait. Presents one result per instruction to writeback and stalls upstream while a memory access is outstanding.

## Interface
Parameters:
- ACK_TIMEOUT, 255: maximum cycles `dmem_req` stays high without `dmem_ack` before a bus error is raised; range 1..255.

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high; only sampled on the rising edge of clk
- in_valid  in  1  execute presents an instruction this cycle
- in_ready  out  1  stage can accept an instruction; execute holds its outputs while low
- alu_res  in  32  ALU result
- shift_res  in  32  shifter result
- dm_in  in  32  store data (unshifted register value)
- ea  in  32  effective address
- ovfalu  in  1  ALU overflow for this instruction
- res_sel  in  1  1 = shift_res, 0 = alu_res for non-memory results
- mem_rren  in  1  load
- mem_wren  in  1  store; never set together with mem_rren
- size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = reserved (treated as word)
- load_unsigned  in  1  zero-extend byte/halfword loads
- cad  in  5  destination register
- gp_we  in  1  instruction writes the register file
- dmem_req  out  1  memory request
- dmem_we  out  1  request is a write
- dmem_addr  out  32  word address, bits [1:0] always 0
- dmem_be  out  4  byte enables, little-endian lanes (be[0] = bits 7:0)
- dmem_wdata  out  32  lane-replicated store data
- dmem_ack  in  1  access complete; rdata valid in same cycle
- dmem_rdata  in  32  read word
- wb_valid  out  1  one-cycle pulse; result for writeback
- wb_we  out  1  register write enable (qualified)
- wb_cad  out  5  destination register
- wb_data  out  32  result / extended load data
- exc_ovf  out  1  overflow exception, with wb_valid
- exc_adel  out  1  misaligned load, with wb_valid
- exc_ades  out  1  misaligned store, with wb_valid
- exc_bus  out  1  ack timeout, with wb_valid

## Operation
- Reset values: state IDLE, in_ready 1, dmem_req/dmem_we 0, dmem_addr/dmem_be/dmem_wdata 0, wb_* 0, all exc_* 0, timeout counter 0.
- Accept when in_valid & in_ready. Capture all inputs into an internal register.
- Misalignment: halfword with ea[0]=1, or word with ea[1:0]≠0. The instruction issues no memory request. The exception flag is set and wb_we=0.
- ovfalu=1: no memory request (stores suppressed), exc_ovf=1, wb_we=0.
- Byte enables: byte 4'b0001<<ea[1:0]; halfword 4'b0011<<ea[1:0]; word 4'b1111.
- Write data: the byte is replicated ×4; the halfword is replicated ×2.
- Load extraction: select the lane by ea[1:0]. Sign- or zero-extend per load_unsigned.
- Stores: wb_we=0 and wb_data=0.
- Non-memory ops: wb_data = res_sel ? shift_res : alu_res; wb_we = gp_we.
- FSM states:
  - IDLE: on accept of a valid memory op → REQ. On accept of anything else → IDLE, with the wb pulse next cycle.
  - REQ: dmem_req=1; address, be, we and wdata are stable. On dmem_ack → IDLE and the wb pulse next cycle, with load data registered. When the counter reaches ACK_TIMEOUT without ack → IDLE, with exc_bus=1 and wb_we=0.
- in_ready = (state==IDLE). At most one exception flag is set per result. Priority: ovf > adel/ades > bus.
- Reset mid-access: dmem_req drops on the next edge. Any ack arriving after reset is ignored. No wb pulse is produced for the aborted instruction.

## Timing
- Non-memory op: accepted at edge N, wb_valid high for cycle N+1 only. Throughput is 1 per cycle.
- Memory op: accepted at edge N. dmem_req is high from cycle N+1.
  - Ack at cycle N+k: wb_valid is high in cycle N+k+1. The next instruction can be accepted at edge N+k+1.
  - Minimum load/store latency is 2 cycles, with 1 bubble.
- Ack in the first REQ cycle is legal. The timeout counter resets on every entry into REQ.

## Structure
- Shared package holds:
  - size encodings (SZ_BYTE/SZ_HALF/SZ_WORD)
  - FSM state constants
  - exception code constants used by writeback/CP0
- One sub-module is natural: load_align (combinational lane select + extension, 32b word, 2b offset, size, unsigned → 32b).

## Test plan
- add: alu_res=0x00000005, res_sel=0, cad=3, gp_we=1 → next cycle wb_valid=1, wb_data=5, wb_cad=3, wb_we=1; in_ready stays 1.
- lb, ea=0x1003, rdata=0x80FF_0000, ack after 3 cycles → dmem_addr=0x1000, be=4'b1000. wb_data=0xFFFFFF80; with load_unsigned → 0x00000080. wb_valid arrives the cycle after ack.
- sh, ea=0x2002, dm_in=0x1234ABCD → dmem_we=1, be=4'b1100, wdata=0xABCDABCD, wb_we=0.
- lw, ea=0x0006 → no dmem_req, exc_adel=1, wb_we=0. sw with ovfalu=1 → no dmem_req, exc_ovf=1.
- Load with ACK_TIMEOUT=4 and no ack → dmem_req high 4 cycles, then exc_bus=1 and in_ready returns to 1.
- Reset asserted during REQ → next cycle dmem_req=0, in_ready=1. A late ack produces no wb_valid.
